// File: rtl/fifo_pkg.sv
// Shared FIFO types.
// fifo_status_t bundles the FIFO status flags so that consumers can pass
// them around as one value.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/param_fifo_if.sv
// Data handshake bundle between a FIFO producer/consumer and param_fifo.
//   fifo_data_in      : write data
//   fifo_data_push    : write request
//   fifo_data_pop     : read request
//   fifo_data_out     : head entry (show-ahead)
//   fifo_data_out_vld : head entry valid
// master = the side driving push/pop; slave = the FIFO.
interface param_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] fifo_data_in;
    logic                  fifo_data_push;
    logic                  fifo_data_pop;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_data_out_vld;

    modport master (
        output fifo_data_in, fifo_data_push, fifo_data_pop,
        input  fifo_data_out, fifo_data_out_vld
    );

    modport slave (
        input  fifo_data_in, fifo_data_push, fifo_data_pop,
        output fifo_data_out, fifo_data_out_vld
    );
endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write index
//   wr_data : write data
//   rd_addr : read index
//   rd_data : combinational read data
module fifo_mem #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous show-ahead FIFO.
//   clk, reset         : clock, synchronous active-high reset
//   fifo_flush         : discard all entries (beats push/pop)
//   fifo_err_clr       : clear sticky overflow/underflow
//   bus (slave)        : data in, push, pop, data out, data valid
//   fifo_full/empty    : occupancy == DEPTH / == 0
//   fifo_almost_full   : occupancy >= AF_LEVEL
//   fifo_almost_empty  : occupancy <= AE_LEVEL
//   fifo_count         : occupancy 0..DEPTH
//   fifo_overflow      : sticky, push while full without a pop
//   fifo_underflow     : sticky, pop while empty
// DEPTH must be a power of two and at least 4.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fifo_flush,
    input  logic                     fifo_err_clr,
    param_fifo_if.slave              bus,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     fifo_almost_full,
    output logic                     fifo_almost_empty,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_overflow,
    output logic                     fifo_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AF_CNT  = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT  = CW'(AE_LEVEL);
    localparam logic [CW-1:0] ONE     = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit above the index.
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  idx_eq;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  ovf_evt;
    logic                  udf_evt;
    fifo_status_t          status;

    assign idx_eq = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign status.empty        = idx_eq && (wr_ptr[AW] == rd_ptr[AW]);
    assign status.full         = idx_eq && (wr_ptr[AW] != rd_ptr[AW]);
    assign status.almost_full  = (count_q >= AF_CNT);
    assign status.almost_empty = (count_q <= AE_CNT);
    assign status.overflow     = ovf_q;
    assign status.underflow    = udf_q;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when paired with an accepted pop. Flushed requests do nothing.
    assign pop_ok  = bus.fifo_data_pop && !status.empty && !fifo_flush;
    assign push_ok = bus.fifo_data_push && (!status.full || pop_ok) && !fifo_flush;
    assign ovf_evt = bus.fifo_data_push && status.full && !pop_ok && !fifo_flush;
    assign udf_evt = bus.fifo_data_pop && status.empty && !fifo_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (fifo_flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + ONE;
                if (pop_ok)  rd_ptr <= rd_ptr + ONE;
                if (push_ok && !pop_ok)      count_q <= count_q + ONE;
                else if (pop_ok && !push_ok) count_q <= count_q - ONE;
            end
            // A fresh error event wins over a simultaneous clear.
            ovf_q <= ovf_evt || (ovf_q && !fifo_err_clr);
            udf_q <= udf_evt || (udf_q && !fifo_err_clr);
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (bus.fifo_data_in),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

    assign bus.fifo_data_out     = status.empty ? '0 : rd_data;
    assign bus.fifo_data_out_vld = !status.empty;

    assign fifo_full         = status.full;
    assign fifo_empty        = status.empty;
    assign fifo_almost_full  = status.almost_full;
    assign fifo_almost_empty = status.almost_empty;
    assign fifo_count        = count_q;
    assign fifo_overflow     = status.overflow;
    assign fifo_underflow    = status.underflow;

endmodule

// File: tb/tb_param_fifo.sv
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_flush = 1'b0;
    logic       fifo_err_clr = 1'b0;
    logic       fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
    logic [4:0] fifo_count;
    logic       fifo_overflow, fifo_underflow;

    int checks = 0;
    int failures = 0;

    param_fifo_if #(.DATA_WIDTH(8)) bus ();

    param_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_flush        (fifo_flush),
        .fifo_err_clr      (fifo_err_clr),
        .bus               (bus),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_count        (fifo_count),
        .fifo_overflow     (fifo_overflow),
        .fifo_underflow    (fifo_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pu;
        logic       po;
        logic       fl;
        logic       ec;
        logic [7:0] din;
        int         cnt;
        logic [7:0] head;
        logic       vld;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs [12];
    logic [7:0] q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then release them just after the edge.
    task automatic step(input logic pu, input logic po, input logic fl,
                        input logic ec, input logic [7:0] d);
        bus.fifo_data_push = pu;
        bus.fifo_data_pop  = po;
        bus.fifo_data_in   = d;
        fifo_flush         = fl;
        fifo_err_clr       = ec;
        @(posedge clk);
        #1;
        bus.fifo_data_push = 1'b0;
        bus.fifo_data_pop  = 1'b0;
        bus.fifo_data_in   = 8'h00;
        fifo_flush         = 1'b0;
        fifo_err_clr       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(fifo_count), 0);
        chk({tag, "_empty"}, 32'(fifo_empty), 1);
        chk({tag, "_full"}, 32'(fifo_full), 0);
        chk({tag, "_afull"}, 32'(fifo_almost_full), 0);
        chk({tag, "_aempty"}, 32'(fifo_almost_empty), 1);
        chk({tag, "_dout"}, 32'(bus.fifo_data_out), 0);
        chk({tag, "_vld"}, 32'(bus.fifo_data_out_vld), 0);
        chk({tag, "_ovf"}, 32'(fifo_overflow), 0);
        chk({tag, "_udf"}, 32'(fifo_underflow), 0);
    endtask

    initial begin
        //            pu po fl ec din    cnt head   vld ovf udf
        vecs[0]  = '{1, 0, 0, 0, 8'h11, 1, 8'h11, 1, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 8'h22, 2, 8'h11, 1, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 8'h00, 1, 8'h22, 1, 0, 0};
        vecs[3]  = '{1, 1, 0, 0, 8'h33, 1, 8'h33, 1, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0};
        vecs[5]  = '{0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1};
        vecs[6]  = '{0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0};
        vecs[7]  = '{1, 1, 0, 0, 8'h44, 1, 8'h44, 1, 0, 1};
        vecs[8]  = '{0, 1, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0};
        vecs[9]  = '{0, 1, 0, 1, 8'h00, 0, 8'h00, 0, 0, 1};
        vecs[10] = '{0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0};
        vecs[11] = '{1, 0, 1, 0, 8'h55, 0, 8'h00, 0, 0, 0};

        bus.fifo_data_push = 1'b0;
        bus.fifo_data_pop  = 1'b0;
        bus.fifo_data_in   = 8'h00;

        do_reset();
        chk_reset_state("por");

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].pu, vecs[i].po, vecs[i].fl, vecs[i].ec, vecs[i].din);
            chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_head", i), 32'(bus.fifo_data_out), 32'(vecs[i].head));
            chk($sformatf("vec%0d_vld", i), 32'(bus.fifo_data_out_vld), 32'(vecs[i].vld));
            chk($sformatf("vec%0d_ovf", i), 32'(fifo_overflow), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_udf", i), 32'(fifo_underflow), 32'(vecs[i].udf));
        end

        // Fill 0x01..0x10, then overflow.
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            step(1, 0, 0, 0, 8'(k));
            chk($sformatf("fill%0d_count", k), 32'(fifo_count), 32'(k));
            chk($sformatf("fill%0d_afull", k), 32'(fifo_almost_full), 32'(k >= 14));
            chk($sformatf("fill%0d_aempty", k), 32'(fifo_almost_empty), 32'(k <= 2));
            chk($sformatf("fill%0d_full", k), 32'(fifo_full), 32'(k == 16));
            chk($sformatf("fill%0d_head", k), 32'(bus.fifo_data_out), 32'h01);
        end
        step(1, 0, 0, 0, 8'h99);
        chk("ovf_set", 32'(fifo_overflow), 1);
        chk("ovf_count", 32'(fifo_count), 16);
        chk("ovf_head", 32'(bus.fifo_data_out), 32'h01);
        step(0, 0, 0, 1, 8'h00);
        chk("ovf_clr", 32'(fifo_overflow), 0);

        // Drain, then underflow.
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("drain%0d_head", k), 32'(bus.fifo_data_out), 32'(k));
            step(0, 1, 0, 0, 8'h00);
            chk($sformatf("drain%0d_count", k), 32'(fifo_count), 32'(16 - k));
        end
        chk("drain_empty", 32'(fifo_empty), 1);
        chk("drain_vld", 32'(bus.fifo_data_out_vld), 0);
        step(0, 1, 0, 0, 8'h00);
        chk("udf_set", 32'(fifo_underflow), 1);
        chk("udf_count", 32'(fifo_count), 0);
        step(0, 0, 0, 1, 8'h00);

        // Push + pop while full.
        for (int k = 1; k <= 16; k++) step(1, 0, 0, 0, 8'(k));
        step(1, 1, 0, 0, 8'hAA);
        chk("fullpp_head", 32'(bus.fifo_data_out), 32'h02);
        chk("fullpp_count", 32'(fifo_count), 16);
        chk("fullpp_full", 32'(fifo_full), 1);
        chk("fullpp_ovf", 32'(fifo_overflow), 0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("fullpp_pop%0d", k), 32'(bus.fifo_data_out),
                (k == 15) ? 32'hAA : 32'(k + 2));
            step(0, 1, 0, 0, 8'h00);
        end
        chk("fullpp_empty", 32'(fifo_empty), 1);

        // Wrap-around against a queue model, occupancy kept in 1..5.
        do_reset();
        q.delete();
        step(1, 0, 0, 0, 8'hC0);
        q.push_back(8'hC0);
        for (int i = 0; i < 40; i++) begin
            logic pu, po;
            int   r;
            logic [7:0] d;
            r  = int'($urandom_range(0, 2));
            pu = (r != 1);
            po = (r != 0);
            if (q.size() == 1) po = 1'b0;
            if (q.size() == 5) pu = 1'b0;
            if (!pu && !po) pu = 1'b1;
            d = 8'(i * 7 + 3);
            if (po) void'(q.pop_front());
            if (pu) q.push_back(d);
            step(pu, po, 0, 0, d);
            chk($sformatf("wrap%0d_count", i), 32'(fifo_count), 32'(q.size()));
            chk($sformatf("wrap%0d_head", i), 32'(bus.fifo_data_out), 32'(q[0]));
        end
        chk("wrap_ovf", 32'(fifo_overflow), 0);
        chk("wrap_udf", 32'(fifo_underflow), 0);

        // Flush with push and pop in the same cycle.
        do_reset();
        for (int k = 0; k < 7; k++) step(1, 0, 0, 0, 8'(k + 8'h40));
        chk("preflush_count", 32'(fifo_count), 7);
        step(1, 1, 1, 0, 8'h77);
        chk("flush_count", 32'(fifo_count), 0);
        chk("flush_empty", 32'(fifo_empty), 1);
        chk("flush_ovf", 32'(fifo_overflow), 0);
        chk("flush_udf", 32'(fifo_underflow), 0);
        step(0, 1, 1, 0, 8'h00);
        chk("flush_pop_empty_udf", 32'(fifo_underflow), 0);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 0, 8'h00);
        chk("flush_keeps_udf", 32'(fifo_underflow), 1);

        // Reset mid-fill.
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 8'(k + 8'h60));
        chk("premid_count", 32'(fifo_count), 5);
        bus.fifo_data_push = 1'b1;
        bus.fifo_data_in   = 8'hEE;
        do_reset();
        bus.fifo_data_push = 1'b0;
        chk_reset_state("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; must be a power of two and at least 4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost-full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, occupancy at or below which almost-empty asserts.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port fifo_flush, input, 1, discards all stored entries.
REQ-008 SHALL have port fifo_err_clr, input, 1, clears sticky error flags.
REQ-009 SHALL have port fifo_data_in, input, DATA_WIDTH, write data.
REQ-010 SHALL have port fifo_data_push, input, 1, write request.
REQ-011 SHALL have port fifo_data_pop, input, 1, read request.
REQ-012 SHALL have port fifo_data_out, output, DATA_WIDTH, head entry (show-ahead).
REQ-013 SHALL have port fifo_data_out_vld, output, 1, head entry valid.
REQ-014 SHALL have ports fifo_full and fifo_empty, output, 1 each, occupancy equal to DEPTH or 0.
REQ-015 SHALL have ports fifo_almost_full and fifo_almost_empty, output, 1 each, threshold flags.
REQ-016 SHALL have port fifo_count, output, $clog2(DEPTH)+1, current occupancy 0..DEPTH.
REQ-017 SHALL have ports fifo_overflow and fifo_underflow, output, 1 each, sticky error flags.

Function
REQ-018 SHALL use all DEPTH entries; read and write pointers carry one extra wrap bit; full = pointer indices equal and wrap bits differ; empty = pointers fully equal.
REQ-019 SHALL accept a pop when pop=1 and not empty; the accepted pop advances the read pointer modulo DEPTH.
REQ-020 SHALL accept a push when push=1 and (not full, or a pop is accepted in the same cycle); the accepted push writes fifo_data_in at the write pointer and advances it modulo DEPTH.
REQ-021 SHALL leave fifo_count unchanged on simultaneous accepted push and pop, including when full; it increments on push only and decrements on pop only.
REQ-022 SHALL present fifo_data_out combinationally from the head entry when not empty, else 0; fifo_data_out_vld = not empty.
REQ-023 SHALL show a word pushed into an empty FIFO on fifo_data_out in the cycle after the push (latency 1); pop on empty with push same cycle is rejected, the push is accepted.
REQ-024 SHALL derive all status outputs from registered pointers and count; no input-to-flag combinational path.
REQ-025 SHALL set fifo_overflow when push=1, full, and no pop accepted; the push is dropped and contents are unchanged.
REQ-026 SHALL set fifo_underflow when pop=1 and empty; the pop is ignored.
REQ-027 SHALL give a new error event priority over fifo_err_clr in the same cycle; otherwise err_clr clears both flags on the next edge.
REQ-028 SHALL give fifo_flush priority over push and pop; the next cycle has count 0 and empty=1, and no error flag is raised by a flushed request; flush does not clear error flags.

Reset
REQ-029 SHALL on reset=1 at a clock edge set both pointers, fifo_count, fifo_overflow and fifo_underflow to 0, so empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, vld=0.
REQ-030 SHALL not reset storage contents; reset asserted mid-operation discards all entries exactly as at power-up.

Structure
REQ-031 SHALL define fifo_status_t (full, empty, almost_full, almost_empty, overflow, underflow) in shared package fifo_pkg for reuse by consumers.
REQ-032 SHALL place storage in one sub-module fifo_mem (1 write port, 1 async read port, DATA_WIDTH x DEPTH, no reset); pointer and flag logic stays in param_fifo.

Verification
REQ-033 SHALL cover a fill sequence: with DEPTH=16, push 0x01..0x10 -> count=16, full=1, almost_full from count 14; a 17th push sets overflow and the head remains 0x01.
REQ-034 SHALL cover a drain sequence: pop 16 times -> outputs 0x01..0x10 in order, empty=1 afterwards; a 17th pop sets underflow and count stays 0.
REQ-035 SHALL cover simultaneous push and pop when full: push 0xAA with pop -> head advances, count=16, no overflow, and 0xAA emerges 16 pops later.
REQ-036 SHALL cover wrap-around: 40 interleaved push/pop with count between 1 and 5 -> data order preserved across pointer wrap, and count matches the reference model every cycle.
REQ-037 SHALL cover flush and reset: flush with count=7 plus push and pop same cycle -> count=0, no error set; reset mid-fill -> all outputs at REQ-029 values next cycle.
